// File: rtl/codec_i2c_sched.sv
// rtl/codec_i2c_sched.sv - round-robin scheduler sharing one I2C byte-write engine
// between codec-register writers, with NACK retry and inter-frame bus gap.
module codec_i2c_sched #(
  parameter int           NREQ      = 4,
  parameter int           MAX_RETRY = 3,
  parameter logic [7:0]   DEV_ADDR  = 8'h34,
  parameter int           GAP_TICKS = 2,
  localparam int          IW        = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic [NREQ-1:0]   req,
  input  logic [16*NREQ-1:0] req_word,
  output logic [NREQ-1:0]   grant_done,
  output logic [NREQ-1:0]   grant_err,
  output logic              busy,
  output logic [IW-1:0]     cur_idx,
  output logic              i2c_go,
  output logic [23:0]       i2c_data,
  input  logic              i2c_done,
  input  logic              i2c_ack
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] WAIT_BUSY = 3'd1;
  localparam logic [2:0] WAIT_DONE = 3'd2;
  localparam logic [2:0] RETRY     = 3'd3;
  localparam logic [2:0] GAP       = 3'd4;

  localparam logic [2:0] MAX_R     = 3'(MAX_RETRY);
  localparam logic [3:0] GAP_LAST  = 4'(GAP_TICKS - 1);
  localparam logic [3:0] BUSY_LAST = 4'd3;

  logic [2:0]      state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   cur_q, cur_d;
  logic [2:0]      retry_q, retry_d;
  logic [3:0]      tick_q, tick_d;
  logic            go_q, go_d;
  logic [23:0]     data_q, data_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [NREQ-1:0] err_q, err_d;

  logic [15:0]     words [NREQ];
  logic [15:0]     sel_word;
  logic [IW-1:0]   win;
  logic [IW-1:0]   cand;
  logic            found;

  // Rotating priority: first pending requester after the last winner.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(ptr_q) + k) % NREQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      words[i] = req_word[16*i +: 16];
    end
    sel_word = words[win];
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cur_d   = cur_q;
    retry_d = retry_q;
    tick_d  = tick_q;
    go_d    = go_q;
    data_d  = data_q;
    done_d  = '0;
    err_d   = '0;
    if (en) begin
      case (state_q)
        IDLE: begin
          if (found) begin
            ptr_d   = win;
            cur_d   = win;
            data_d  = {DEV_ADDR, sel_word};
            go_d    = 1'b1;
            retry_d = '0;
            tick_d  = '0;
            state_d = WAIT_BUSY;
          end
        end
        // done still high here is left over from the previous frame.
        WAIT_BUSY: begin
          if (!i2c_done) begin
            state_d = WAIT_DONE;
          end else if (tick_q == BUSY_LAST) begin
            go_d          = 1'b0;
            err_d[cur_q]  = 1'b1;
            tick_d        = '0;
            state_d       = GAP;
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end
        WAIT_DONE: begin
          if (i2c_done) begin
            go_d   = 1'b0;
            tick_d = '0;
            if (!i2c_ack) begin
              done_d[cur_q] = 1'b1;
              state_d       = GAP;
            end else if (retry_q < MAX_R) begin
              retry_d = retry_q + 3'd1;
              state_d = RETRY;
            end else begin
              err_d[cur_q] = 1'b1;
              state_d      = GAP;
            end
          end
        end
        RETRY: begin
          go_d    = 1'b1;
          tick_d  = '0;
          state_d = WAIT_BUSY;
        end
        GAP: begin
          if (tick_q == GAP_LAST) begin
            tick_d  = '0;
            state_d = IDLE;
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end
        default: begin
          go_d    = 1'b0;
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= IW'(NREQ - 1);
      cur_q   <= '0;
      retry_q <= '0;
      tick_q  <= '0;
      go_q    <= 1'b0;
      data_q  <= '0;
      done_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cur_q   <= cur_d;
      retry_q <= retry_d;
      tick_q  <= tick_d;
      go_q    <= go_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign grant_done = done_q;
  assign grant_err  = err_q;
  assign busy       = (state_q != IDLE);
  assign cur_idx    = cur_q;
  assign i2c_go     = go_q;
  assign i2c_data   = data_q;

endmodule
